// File: rtl/processor_pkg.sv
// Shared definitions for the processor front end.
// Contents: opcode constants, instruction field bit positions, the operand
// reader FSM state type, and small opcode-usage helpers.
package processor_pkg;

  localparam logic [4:0] OP_LW  = 5'b00000;
  localparam logic [4:0] OP_MOV = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_NOP = 5'b11111;

  // Instruction field positions (LSB of each field)
  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RD_LSB  = 22;
  localparam int unsigned RS1_LSB = 17;
  localparam int unsigned RS2_LSB = 0;
  localparam int unsigned OPC_W   = 5;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StCapture,
    StOut
  } state_e;

  // Unknown opcodes decode as ADD, so they use both sources and write rd.
  function automatic logic uses_rs1(input logic [4:0] opc);
    return (opc != OP_MOV) && (opc != OP_NOP);
  endfunction

  function automatic logic uses_rs2(input logic [4:0] opc);
    return (opc != OP_LW) && (opc != OP_NOP);
  endfunction

  function automatic logic writes_rd(input logic [4:0] opc);
    return opc != OP_NOP;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard.
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   set_i, set_addr_i         mark a register as having a write in flight
//   clr_i, clr_addr_i         writeback completed for a register
//   lookup1/2_addr_i          combinational busy lookups
//   busy1_o, busy2_o          busy state of the looked-up registers
// A set and a clear of the same index in one cycle leaves the bit set.
module reg_scoreboard #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] lookup1_addr_i,
  input  logic [ADDR_W-1:0] lookup2_addr_i,
  output logic              busy1_o,
  output logic              busy2_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_addr_i] = 1'b0;
    // Applied after the clear so a same-index set wins.
    if (set_i) busy_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy1_o = busy_q[lookup1_addr_i];
  assign busy2_o = busy_q[lookup2_addr_i];

endmodule

// File: rtl/operand_reader.sv
// Operand reader: read-side front end of the register file.
// Accepts one instruction over instr_valid/instr_ready, waits in CHECK while a
// used source register has a write in flight, strobes the register file for
// one cycle, captures the operands the following cycle and presents them over
// op_valid/op_ready.
// Ports:
//   clk_i, reset_i                      clock, asynchronous active-high reset
//   instr_valid_i/instr_ready_o         upstream handshake, instruction_i
//   rf_address1/2_o, rf_enable_read_o   register file read port
//   rf_data_out1/2_i                    read data, one cycle after the strobe
//   wb_valid_i, wb_addr_i               writeback completion (clears busy)
//   op_valid_o/op_ready_i               downstream handshake
//   op_opcode_o, op_rd_o, op_a_o, op_b_o operand bundle
module operand_reader
  import processor_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic [31:0]       instruction_i,
  output logic [ADDR_W-1:0] rf_address1_o,
  output logic [ADDR_W-1:0] rf_address2_o,
  output logic              rf_enable_read_o,
  input  logic [DATA_W-1:0] rf_data_out1_i,
  input  logic [DATA_W-1:0] rf_data_out2_i,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  output logic              op_valid_o,
  input  logic              op_ready_i,
  output logic [4:0]        op_opcode_o,
  output logic [ADDR_W-1:0] op_rd_o,
  output logic [DATA_W-1:0] op_a_o,
  output logic [DATA_W-1:0] op_b_o
);

  state_e              state_q;
  logic                instr_ready_q;
  logic                op_valid_q;
  logic [4:0]          opcode_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [ADDR_W-1:0]   addr1_q, addr2_q;
  logic                use1_q, use2_q, wr_q;
  logic [DATA_W-1:0]   op_a_q, op_b_q;

  logic [4:0]          dec_opc;
  logic                busy1, busy2, hazard, issue;
  logic                unused_instr_bits;

  assign dec_opc = instruction_i[OPC_LSB +: OPC_W];
  assign unused_instr_bits = ^instruction_i[16:5];

  // Busy lookups use the registered read addresses; unused sources are masked.
  assign hazard = (use1_q && busy1) || (use2_q && busy2);
  assign issue  = (state_q == StCheck) && !hazard;

  reg_scoreboard #(
    .NREGS (NREGS),
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .set_i         (issue && wr_q),
    .set_addr_i    (rd_q),
    .clr_i         (wb_valid_i),
    .clr_addr_i    (wb_addr_i),
    .lookup1_addr_i(addr1_q),
    .lookup2_addr_i(addr2_q),
    .busy1_o       (busy1),
    .busy2_o       (busy2)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      instr_ready_q <= 1'b0;
      op_valid_q    <= 1'b0;
      opcode_q      <= '0;
      rd_q          <= '0;
      addr1_q       <= '0;
      addr2_q       <= '0;
      use1_q        <= 1'b0;
      use2_q        <= 1'b0;
      wr_q          <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          instr_ready_q <= 1'b1;
          if (instr_valid_i && instr_ready_q) begin
            opcode_q      <= dec_opc;
            rd_q          <= instruction_i[RD_LSB +: ADDR_W];
            use1_q        <= uses_rs1(dec_opc);
            use2_q        <= uses_rs2(dec_opc);
            wr_q          <= writes_rd(dec_opc);
            // Unused read ports are driven to register 0.
            addr1_q       <= uses_rs1(dec_opc) ? instruction_i[RS1_LSB +: ADDR_W] : '0;
            addr2_q       <= uses_rs2(dec_opc) ? instruction_i[RS2_LSB +: ADDR_W] : '0;
            instr_ready_q <= 1'b0;
            state_q       <= StCheck;
          end
        end
        StCheck: begin
          if (!hazard) state_q <= StCapture;
        end
        StCapture: begin
          op_a_q     <= use1_q ? rf_data_out1_i : '0;
          op_b_q     <= use2_q ? rf_data_out2_i : '0;
          op_valid_q <= 1'b1;
          state_q    <= StOut;
        end
        StOut: begin
          if (op_ready_i) begin
            op_valid_q    <= 1'b0;
            instr_ready_q <= 1'b1;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign instr_ready_o    = instr_ready_q;
  assign rf_address1_o    = addr1_q;
  assign rf_address2_o    = addr2_q;
  assign rf_enable_read_o = issue;
  assign op_valid_o       = op_valid_q;
  assign op_opcode_o      = opcode_q;
  assign op_rd_o          = rd_q;
  assign op_a_o           = op_a_q;
  assign op_b_o           = op_b_q;

endmodule

// File: tb/tb_operand_reader.sv
// Testbench for operand_reader: directed vector table, hand-written hazard /
// backpressure / set-wins / reset sequences, and a randomized phase checked
// against a transaction-level model of the scoreboard and operand selection.
module tb_operand_reader;

  localparam logic [4:0] LW  = 5'b00000;
  localparam logic [4:0] MOV = 5'b00010;
  localparam logic [4:0] ADD = 5'b00011;
  localparam logic [4:0] NOP = 5'b11111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instruction = '0;
  logic [4:0]  rf_address1, rf_address2;
  logic        rf_enable_read;
  logic [31:0] rf_data_out1 = '0, rf_data_out2 = '0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [4:0]  op_opcode, op_rd;
  logic [31:0] op_a, op_b;

  logic [31:0] mem [32];
  logic [31:0] mb;   // model busy vector
  int n_checks = 0;
  int n_fail = 0;

  operand_reader dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .instr_valid_i   (instr_valid),
    .instr_ready_o   (instr_ready),
    .instruction_i   (instruction),
    .rf_address1_o   (rf_address1),
    .rf_address2_o   (rf_address2),
    .rf_enable_read_o(rf_enable_read),
    .rf_data_out1_i  (rf_data_out1),
    .rf_data_out2_i  (rf_data_out2),
    .wb_valid_i      (wb_valid),
    .wb_addr_i       (wb_addr),
    .op_valid_o      (op_valid),
    .op_ready_i      (op_ready),
    .op_opcode_o     (op_opcode),
    .op_rd_o         (op_rd),
    .op_a_o          (op_a),
    .op_b_o          (op_b)
  );

  always #5 clk = ~clk;

  // Register file model: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rf_enable_read) begin
      rf_data_out1 <= mem[rf_address1];
      rf_data_out2 <= mem[rf_address2];
    end
  end

  typedef struct {
    logic [4:0]  opc, rd, rs1, rs2;
    logic [31:0] exp_a, exp_b;
    logic [4:0]  exp_addr1, exp_addr2;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] opc, rd, rs1, rs2);
    logic [11:0] junk;
    junk = 12'($urandom);
    return {opc, rd, rs1, junk, rs2};
  endfunction

  // Source usage straight from the opcode table; unknown opcodes behave as ADD.
  function automatic logic [1:0] src_use(input logic [4:0] opc);
    case (opc)
      LW:      return 2'b10;
      MOV:     return 2'b01;
      NOP:     return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [31:0] dut_busy();
    return dut.u_scoreboard.busy_q;
  endfunction

  task automatic send(input logic [31:0] ins);
    int w;
    w = 0;
    while (!instr_ready && w < 10) begin
      step();
      w++;
    end
    check("instr_ready before send", instr_ready, 1);
    instr_valid = 1'b1;
    instruction = ins;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic clear_reg(input logic [4:0] r);
    wb_valid = 1'b1;
    wb_addr  = r;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit clear_after);
    send(mk(v.opc, v.rd, v.rs1, v.rs2));
    check("c1 enable", rf_enable_read, 1);
    check("c1 addr1", rf_address1, v.exp_addr1);
    check("c1 addr2", rf_address2, v.exp_addr2);
    check("c1 instr_ready", instr_ready, 0);
    step();
    check("c2 enable", rf_enable_read, 0);
    check("c2 op_valid", op_valid, 0);
    step();
    check("c3 op_valid", op_valid, 1);
    check("c3 op_a", op_a, v.exp_a);
    check("c3 op_b", op_b, v.exp_b);
    check("c3 op_rd", op_rd, v.rd);
    check("c3 op_opcode", op_opcode, v.opc);
    check("busy[rd]", dut_busy() >> v.rd & 1, v.exp_busy);
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    check("after accept op_valid", op_valid, 0);
    check("after accept instr_ready", instr_ready, 1);
    if (clear_after && v.exp_busy) clear_reg(v.rd);
  endtask

  initial begin
    logic [31:0] held_a;
    bit seen, issued, abort;
    for (int i = 0; i < 32; i++) mem[i] = 32'h100 + i;
    mem[1] = 10;
    mem[2] = 20;
    mem[5] = 7;

    vecs[0] = '{ADD, 5'd3, 5'd1, 5'd2, 32'd10, 32'd20, 5'd1, 5'd2, 1'b1};
    vecs[1] = '{MOV, 5'd3, 5'd9, 5'd5, 32'd0, 32'd7, 5'd0, 5'd5, 1'b1};
    vecs[2] = '{LW, 5'd7, 5'd4, 5'd6, 32'h104, 32'd0, 5'd4, 5'd0, 1'b1};
    vecs[3] = '{NOP, 5'd8, 5'd10, 5'd11, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0};
    vecs[4] = '{5'b01010, 5'd0, 5'd30, 5'd31, 32'h11e, 32'h11f, 5'd30, 5'd31, 1'b1};
    vecs[5] = '{ADD, 5'd31, 5'd0, 5'd0, 32'h100, 32'h100, 5'd0, 5'd0, 1'b1};

    // Reset state
    repeat (3) step();
    check("reset instr_ready", instr_ready, 0);
    check("reset op_valid", op_valid, 0);
    check("reset enable", rf_enable_read, 0);
    check("reset op_a", op_a, 0);
    check("reset busy", dut_busy(), 0);
    reset = 1'b0;
    check("instr_ready before first edge", instr_ready, 0);
    step();
    check("instr_ready after first edge", instr_ready, 1);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], 1'b1);
      check("busy clear after vector", dut_busy(), 0);
    end

    // Hazard: busy[3] left set, then ADD rd4 rs1=3 stalls until writeback.
    run_vec(vecs[0], 1'b0);
    send(mk(ADD, 5'd4, 5'd3, 5'd2));
    for (int c = 1; c <= 4; c++) begin
      check("hazard stall enable", rf_enable_read, 0);
      step();
    end
    check("hazard c5 enable", rf_enable_read, 0);
    wb_valid = 1'b1;
    wb_addr = 5'd3;
    step();
    wb_valid = 1'b0;
    check("hazard c6 enable", rf_enable_read, 1);
    check("hazard c6 addr1", rf_address1, 3);
    step();
    check("hazard c7 op_valid", op_valid, 0);
    step();
    check("hazard c8 op_valid", op_valid, 1);
    check("hazard op_a", op_a, mem[3]);
    check("hazard op_b", op_b, 20);
    // Backpressure: hold op_ready low for five cycles
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp op_valid", op_valid, 1);
      check("bp op_a", op_a, mem[3]);
      check("bp op_rd", op_rd, 4);
      check("bp instr_ready", instr_ready, 0);
    end
    op_ready = 1'b1;
    check("bp accept op_valid", op_valid, 1);
    step();
    op_ready = 1'b0;
    check("bp after op_valid", op_valid, 0);
    check("bp after instr_ready", instr_ready, 1);
    clear_reg(5'd4);
    check("busy after hazard seq", dut_busy(), 0);

    // Set wins over a same-cycle clear of the same register.
    send(mk(ADD, 5'd2, 5'd6, 5'd7));
    check("setwins enable", rf_enable_read, 1);
    wb_valid = 1'b1;
    wb_addr = 5'd2;
    step();
    wb_valid = 1'b0;
    check("setwins busy", dut_busy(), 32'h4);
    step();
    check("setwins op_valid", op_valid, 1);
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    clear_reg(5'd2);

    // Reset during CAPTURE
    send(mk(ADD, 5'd9, 5'd1, 5'd2));
    step();
    reset = 1'b1;
    #1;
    check("midreset op_valid", op_valid, 0);
    check("midreset enable", rf_enable_read, 0);
    check("midreset instr_ready", instr_ready, 0);
    check("midreset addr1", rf_address1, 0);
    check("midreset addr2", rf_address2, 0);
    check("midreset op_a", op_a, 0);
    check("midreset op_b", op_b, 0);
    check("midreset op_rd", op_rd, 0);
    check("midreset op_opcode", op_opcode, 0);
    check("midreset busy", dut_busy(), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (op_valid) seen = 1;
    end
    check("no op_valid for discarded", seen, 0);
    send(mk(NOP, 5'd12, 5'd1, 5'd2));
    step();
    step();
    check("nop op_valid", op_valid, 1);
    check("nop op_a", op_a, 0);
    check("nop op_b", op_b, 0);
    check("nop busy", dut_busy(), 0);
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;

    // Randomized phase against the transaction-level model
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mb = '0;
    abort = 0;
    for (int n = 0; n < 60 && !abort; n++) begin
      logic [4:0] opc, rd, rs1, rs2, r;
      logic [1:0] u;
      logic hz;
      case ($urandom % 5)
        0: opc = LW;
        1: opc = MOV;
        2: opc = ADD;
        3: opc = NOP;
        default: opc = 5'($urandom);
      endcase
      rd = 5'($urandom);
      rs1 = 5'($urandom);
      rs2 = 5'($urandom);
      u = src_use(opc);
      if ($urandom % 2 == 1) begin
        r = 5'($urandom);
        mb[r] = 1'b0;
        clear_reg(r);
      end
      send(mk(opc, rd, rs1, rs2));
      issued = 0;
      for (int c = 0; c < 40 && !issued; c++) begin
        hz = (u[1] && mb[rs1]) || (u[0] && mb[rs2]);
        check("rnd enable vs hazard", rf_enable_read, !hz);
        if (rf_enable_read) begin
          issued = 1;
          check("rnd addr1", rf_address1, u[1] ? rs1 : 5'd0);
          check("rnd addr2", rf_address2, u[0] ? rs2 : 5'd0);
          if ($urandom % 4 == 0) begin
            r = 5'($urandom);
            wb_valid = 1'b1;
            wb_addr = r;
            mb[r] = 1'b0;
          end
          if (opc != NOP) mb[rd] = 1'b1;
        end else if (hz && $urandom % 2 == 1) begin
          r = (u[1] && mb[rs1]) ? rs1 : rs2;
          wb_valid = 1'b1;
          wb_addr = r;
          mb[r] = 1'b0;
        end
        step();
        wb_valid = 1'b0;
      end
      if (!issued) begin
        check("rnd issue within bound", issued, 1);
        abort = 1;
      end else begin
        check("rnd early op_valid", op_valid, 0);
        step();
        check("rnd op_valid", op_valid, 1);
        check("rnd op_a", op_a, u[1] ? mem[rs1] : 32'd0);
        check("rnd op_b", op_b, u[0] ? mem[rs2] : 32'd0);
        check("rnd op_rd", op_rd, rd);
        check("rnd op_opcode", op_opcode, opc);
        held_a = op_a;
        for (int k = 0; k < int'($urandom % 3); k++) begin
          step();
          check("rnd bp op_valid", op_valid, 1);
          check("rnd bp op_a", op_a, held_a);
        end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        check("rnd done op_valid", op_valid, 0);
        check("rnd busy vector", dut_busy(), mb);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
